// File: rtl/pcap_global_hdr_strip.sv
// Strips and validates the 24-byte pcap global header from a 128-bit byte stream,
// exports the header fields and re-aligns the record bytes so file byte 24 is lane 0.
module pcap_global_hdr_strip (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [127:0] S_TDATA,
  input  logic [15:0]  S_TKEEP,
  input  logic         S_TVALID,
  output logic         S_TREADY,
  input  logic         S_TLAST,
  output logic [127:0] PCAP_TDATA,
  output logic [15:0]  PCAP_TKEEP,
  output logic         PCAP_TVALID,
  input  logic         PCAP_TREADY,
  output logic         PCAP_TLAST,
  output logic         HDR_OK,
  output logic         HDR_ERR,
  output logic         SWAPPED,
  output logic         NANOSEC,
  output logic [31:0]  SNAPLEN,
  output logic [31:0]  LINKTYPE
);

  typedef enum logic [2:0] {HDR0, HDR1, STREAM, FLUSH, DROP} state_t;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  state_t       state, state_nxt;
  logic [63:0]  hold, hold_nxt;
  logic [7:0]   hold_keep, hold_keep_nxt;
  beat_t        out_q, emit_beat;
  logic         out_vld, emit;
  logic [127:0] emit_data_m;

  logic         ok_nxt, err_nxt, swp_nxt, ns_nxt;
  logic [31:0]  snap_nxt, link_nxt;
  logic         magic_ok, magic_swp, magic_ns;
  logic         slot_free, accept;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  assign slot_free = !out_vld || PCAP_TREADY;
  // Gated by reset so every output reads 0 while RST_N is low.
  assign S_TREADY  = RST_N && (state != FLUSH) && slot_free;
  assign accept    = S_TVALID && S_TREADY;

  // Magic is the first four file bytes read little-endian.
  always_comb begin
    magic_ok  = 1'b1;
    magic_swp = 1'b0;
    magic_ns  = 1'b0;
    case (S_TDATA[31:0])
      32'hA1B2C3D4: begin end
      32'hA1B23C4D: magic_ns = 1'b1;
      32'hD4C3B2A1: magic_swp = 1'b1;
      32'h4D3CB2A1: begin magic_swp = 1'b1; magic_ns = 1'b1; end
      default:      magic_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold;
    hold_keep_nxt = hold_keep;
    emit          = 1'b0;
    emit_beat     = '0;
    ok_nxt        = HDR_OK;
    err_nxt       = HDR_ERR;
    swp_nxt       = SWAPPED;
    ns_nxt        = NANOSEC;
    snap_nxt      = SNAPLEN;
    link_nxt      = LINKTYPE;
    case (state)
      HDR0: if (accept) begin
        ok_nxt  = 1'b0;
        err_nxt = 1'b0;
        if (!magic_ok || S_TLAST) begin
          err_nxt   = 1'b1;
          state_nxt = S_TLAST ? HDR0 : DROP;
        end else begin
          swp_nxt   = magic_swp;
          ns_nxt    = magic_ns;
          state_nxt = HDR1;
        end
      end
      HDR1: if (accept) begin
        snap_nxt      = SWAPPED ? bswap32(S_TDATA[31:0])  : S_TDATA[31:0];
        link_nxt      = SWAPPED ? bswap32(S_TDATA[63:32]) : S_TDATA[63:32];
        ok_nxt        = 1'b1;
        hold_nxt      = S_TDATA[127:64];
        hold_keep_nxt = S_TKEEP[15:8];
        if (S_TLAST) begin
          state_nxt = HDR0;
          if (!S_TKEEP[7]) begin
            ok_nxt  = 1'b0;
            err_nxt = 1'b1;
          end else if (S_TKEEP[8]) begin
            emit           = 1'b1;
            emit_beat.data = {64'h0, S_TDATA[127:64]};
            emit_beat.keep = {8'h00, S_TKEEP[15:8]};
            emit_beat.last = 1'b1;
          end
        end else begin
          state_nxt = STREAM;
        end
      end
      STREAM: if (accept) begin
        emit           = 1'b1;
        emit_beat.data = {S_TDATA[63:0], hold};
        emit_beat.keep = 16'hFFFF;
        hold_nxt       = S_TDATA[127:64];
        hold_keep_nxt  = S_TKEEP[15:8];
        if (S_TLAST) begin
          // Keep is contiguous from lane 0, so lane 8 tells whether a tail spills over.
          if (!S_TKEEP[8]) begin
            emit_beat.keep = {S_TKEEP[7:0], 8'hFF};
            emit_beat.last = 1'b1;
            state_nxt      = HDR0;
          end else begin
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: if (slot_free) begin
        emit           = 1'b1;
        emit_beat.data = {64'h0, hold};
        emit_beat.keep = {8'h00, hold_keep};
        emit_beat.last = 1'b1;
        state_nxt      = HDR0;
      end
      DROP: if (accept && S_TLAST) state_nxt = HDR0;
      default: state_nxt = HDR0;
    endcase
  end

  // Invalid lanes are driven as zero so downstream never sees stale bytes.
  for (genvar i = 0; i < 16; i++) begin : g_lane
    assign emit_data_m[8*i +: 8] = emit_beat.keep[i] ? emit_beat.data[8*i +: 8] : 8'h00;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= HDR0;
      hold      <= '0;
      hold_keep <= '0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      hold_keep <= hold_keep_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end else if (emit) begin
      out_q   <= '{data: emit_data_m, keep: emit_beat.keep, last: emit_beat.last};
      out_vld <= 1'b1;
    end else if (PCAP_TREADY) begin
      out_vld <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      HDR_OK   <= 1'b0;
      HDR_ERR  <= 1'b0;
      SWAPPED  <= 1'b0;
      NANOSEC  <= 1'b0;
      SNAPLEN  <= '0;
      LINKTYPE <= '0;
    end else begin
      HDR_OK   <= ok_nxt;
      HDR_ERR  <= err_nxt;
      SWAPPED  <= swp_nxt;
      NANOSEC  <= ns_nxt;
      SNAPLEN  <= snap_nxt;
      LINKTYPE <= link_nxt;
    end
  end

  assign PCAP_TDATA  = out_vld ? out_q.data : 128'h0;
  assign PCAP_TKEEP  = out_vld ? out_q.keep : 16'h0;
  assign PCAP_TLAST  = out_vld && out_q.last;
  assign PCAP_TVALID = out_vld;

endmodule

// File: tb/tb_pcap_global_hdr_strip.sv
// Directed bench: a byte-level pcap model predicts header status and the realigned
// record words; one monitor compares every output transfer against it.
module tb_pcap_global_hdr_strip;
  logic         CLK = 1'b0, RST_N = 1'b0;
  logic [127:0] S_TDATA = '0;
  logic [15:0]  S_TKEEP = '0;
  logic         S_TVALID = 1'b0, S_TLAST = 1'b0, S_TREADY;
  logic [127:0] PCAP_TDATA;
  logic [15:0]  PCAP_TKEEP;
  logic         PCAP_TVALID, PCAP_TLAST, PCAP_TREADY = 1'b1;
  logic         HDR_OK, HDR_ERR, SWAPPED, NANOSEC;
  logic [31:0]  SNAPLEN, LINKTYPE;

  always #5 CLK = ~CLK;

  pcap_global_hdr_strip dut (
    .CLK(CLK), .RST_N(RST_N),
    .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TLAST(S_TLAST),
    .PCAP_TDATA(PCAP_TDATA), .PCAP_TKEEP(PCAP_TKEEP), .PCAP_TVALID(PCAP_TVALID),
    .PCAP_TREADY(PCAP_TREADY), .PCAP_TLAST(PCAP_TLAST),
    .HDR_OK(HDR_OK), .HDR_ERR(HDR_ERR), .SWAPPED(SWAPPED), .NANOSEC(NANOSEC),
    .SNAPLEN(SNAPLEN), .LINKTYPE(LINKTYPE)
  );

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  beat_t       expq[$];
  logic [7:0]  fb[$];
  int          tests = 0, fails = 0;
  int          rmode = 0;
  logic        rtog = 1'b1;
  logic        e_ok, e_err, e_swp, e_ns;
  logic [31:0] e_snap, e_link;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic next_rdy();
    case (rmode)
      0: return 1'b1;
      1: begin rtog = ~rtog; return rtog; end
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // File = magic, 12 filler bytes, snaplen, linktype (fields stored little-endian), payload.
  task automatic mk_file(input logic [31:0] magic, input logic [31:0] snap, input logic [31:0] link,
                         input int npay, input logic [7:0] seed);
    fb.delete();
    for (int i = 0; i < 4; i++)  fb.push_back(magic[8*i +: 8]);
    for (int i = 0; i < 12; i++) fb.push_back(8'(8'hE0 + i));
    for (int i = 0; i < 4; i++)  fb.push_back(snap[8*i +: 8]);
    for (int i = 0; i < 4; i++)  fb.push_back(link[8*i +: 8]);
    for (int i = 0; i < npay; i++) fb.push_back(8'(seed + i));
  endtask

  // Reference: header status from the raw bytes, records = file bytes 24.. cut into 16-byte words.
  function automatic void model();
    int n = fb.size();
    logic [31:0] m;
    logic good;
    beat_t b;
    m = {fb[3], fb[2], fb[1], fb[0]};
    good  = 1'b1;
    e_swp = (m == 32'hD4C3B2A1) || (m == 32'h4D3CB2A1);
    e_ns  = (m == 32'hA1B23C4D) || (m == 32'h4D3CB2A1);
    if (!(m == 32'hA1B2C3D4 || m == 32'hA1B23C4D || e_swp)) good = 1'b0;
    if (!good || n < 24) begin
      e_ok = 1'b0; e_err = 1'b1;
      return;
    end
    e_ok = 1'b1; e_err = 1'b0;
    e_snap = {fb[19], fb[18], fb[17], fb[16]};
    e_link = {fb[23], fb[22], fb[21], fb[20]};
    if (e_swp) begin
      e_snap = {e_snap[7:0], e_snap[15:8], e_snap[23:16], e_snap[31:24]};
      e_link = {e_link[7:0], e_link[15:8], e_link[23:16], e_link[31:24]};
    end
    for (int p = 24; p < n; p += 16) begin
      b.d = '0; b.k = '0;
      for (int j = 0; j < 16 && p + j < n; j++) begin
        b.d[8*j +: 8] = fb[p + j];
        b.k[j] = 1'b1;
      end
      b.l = (p + 16 >= n);
      expq.push_back(b);
    end
  endfunction

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send_word(input logic [127:0] d, input logic [15:0] k, input logic l);
    int t = 0;
    S_TDATA = d; S_TKEEP = k; S_TLAST = l; S_TVALID = 1'b1;
    forever begin
      PCAP_TREADY = next_rdy();
      #1;
      if (S_TREADY) break;
      if (++t > 100) begin
        tests++; fails++;
        $display("FAIL s_tready_timeout: got 0 expected 1");
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    S_TVALID = 1'b0; S_TLAST = 1'b0;
  endtask

  task automatic send_file(input int maxw);
    int n = fb.size();
    int w = 0;
    for (int p = 0; p < n && w < maxw; p += 16) begin
      logic [127:0] d = '0;
      logic [15:0]  k = '0;
      for (int j = 0; j < 16 && p + j < n; j++) begin
        d[8*j +: 8] = fb[p + j];
        k[j] = 1'b1;
      end
      send_word(d, k, p + 16 >= n);
      w++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      PCAP_TREADY = next_rdy();
    end
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() != 0 && t < 200) begin idle(1); t++; end
    chk("drain_pending", 128'(expq.size()), 128'd0);
    idle(2);
  endtask

  task automatic check_status();
    chk("hdr_ok", 128'(HDR_OK), 128'(e_ok));
    chk("hdr_err", 128'(HDR_ERR), 128'(e_err));
    if (e_ok) begin
      chk("swapped", 128'(SWAPPED), 128'(e_swp));
      chk("nanosec", 128'(NANOSEC), 128'(e_ns));
      chk("snaplen", 128'(SNAPLEN), 128'(e_snap));
      chk("linktype", 128'(LINKTYPE), 128'(e_link));
    end
  endtask

  // Output monitor: samples after the driver has settled inputs for the coming edge.
  initial begin
    logic stalled_q = 1'b0;
    beat_t prev, b;
    logic [127:0] m;
    forever begin
      @(negedge CLK); #2;
      if (!RST_N) begin stalled_q = 1'b0; continue; end
      if (stalled_q) begin
        chk("stall_data", PCAP_TDATA, prev.d);
        chk("stall_keep", 128'(PCAP_TKEEP), 128'(prev.k));
        chk("stall_last", 128'(PCAP_TLAST), 128'(prev.l));
      end
      if (PCAP_TVALID && !PCAP_TREADY) chk("s_tready_stalled", 128'(S_TREADY), 128'd0);
      if (PCAP_TVALID && PCAP_TREADY) begin
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got data %0h keep %0h expected none", PCAP_TDATA, PCAP_TKEEP);
        end else begin
          b = expq.pop_front();
          m = '0;
          for (int j = 0; j < 16; j++) if (b.k[j]) m[8*j +: 8] = 8'hFF;
          chk("out_data", PCAP_TDATA & m, b.d);
          chk("out_keep", 128'(PCAP_TKEEP), 128'(b.k));
          chk("out_last", 128'(PCAP_TLAST), 128'(b.l));
        end
      end
      stalled_q = PCAP_TVALID && !PCAP_TREADY;
      prev.d = PCAP_TDATA; prev.k = PCAP_TKEEP; prev.l = PCAP_TLAST;
    end
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_tvalid", 128'(PCAP_TVALID), 128'd0);
    chk("rst_tready", 128'(S_TREADY), 128'd0);
    chk("rst_hdr_ok", 128'(HDR_OK), 128'd0);
    chk("rst_hdr_err", 128'(HDR_ERR), 128'd0);
    chk("rst_snaplen", 128'(SNAPLEN), 128'd0);
    chk("rst_tdata", PCAP_TDATA, 128'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // native micro file
    mk_file(32'hA1B2C3D4, 32'h0000FFFF, 32'd1, 40, 8'h00); model();
    chk("t1_nwords", 128'(expq.size()), 128'd3);
    chk("t1_w0", expq[0].d, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t1_w2_keep", 128'(expq[2].k), 128'h00FF);
    chk("t1_w2_last", 128'(expq[2].l), 128'd1);
    send_file(1000); drain(); check_status();
    chk("t1_snaplen_lit", 128'(SNAPLEN), 128'h0000FFFF);
    chk("t1_linktype_lit", 128'(LINKTYPE), 128'd1);
    chk("t1_swapped_lit", 128'(SWAPPED), 128'd0);

    // swapped nanosecond magic
    mk_file(32'h4D3CB2A1, 32'hFFFF0000, 32'h01000000, 20, 8'h40); model();
    send_file(1000); drain(); check_status();
    chk("t2_swapped_lit", 128'(SWAPPED), 128'd1);
    chk("t2_nanosec_lit", 128'(NANOSEC), 128'd1);
    chk("t2_snaplen_lit", 128'(SNAPLEN), 128'h0000FFFF);
    chk("t2_linktype_lit", 128'(LINKTYPE), 128'd1);

    // last word n=12 in STREAM: one-cycle flush
    mk_file(32'hA1B2C3D4, 32'd1500, 32'd105, 36, 8'h80); model();
    chk("t3_flush_keep", 128'(expq[2].k), 128'h000F);
    send_file(1000);
    #1 chk("t3_flush_tready0", 128'(S_TREADY), 128'd0);
    @(negedge CLK); PCAP_TREADY = 1'b1;
    #1 chk("t3_flush_tready1", 128'(S_TREADY), 128'd1);
    drain(); check_status();

    // header-only, tail inside header word, short tail in STREAM, truncated headers
    mk_file(32'hA1B23C4D, 32'd256, 32'd228, 0, 8'h00); model();
    send_file(1000); drain(); check_status();
    mk_file(32'hA1B2C3D4, 32'd64, 32'd1, 5, 8'hC0); model();
    chk("hdr1_tail_keep", 128'(expq[0].k), 128'h001F);
    send_file(1000); drain(); check_status();
    mk_file(32'hA1B2C3D4, 32'd64, 32'd1, 0, 8'h00);
    repeat (4) void'(fb.pop_back());
    model(); send_file(1000); drain(); check_status();
    chk("trunc20_err_lit", 128'(HDR_ERR), 128'd1);
    mk_file(32'hD4C3B2A1, 32'd64, 32'd1, 0, 8'h00);
    repeat (12) void'(fb.pop_back());
    model(); send_file(1000); drain(); check_status();

    // bad magic then a good file
    mk_file(32'hDEADBEEF, 32'd64, 32'd1, 66, 8'h11); model();
    chk("t4_model_noout", 128'(expq.size()), 128'd0);
    send_file(1000); idle(4); check_status();
    chk("t4_err_lit", 128'(HDR_ERR), 128'd1);
    mk_file(32'hA1B2C3D4, 32'd9000, 32'd113, 13, 8'h20); model();
    chk("stream_tail_keep", 128'(expq[0].k), 128'h1FFF);
    send_file(1000); drain(); check_status();
    chk("t4_recover_ok", 128'(HDR_OK), 128'd1);
    chk("t4_recover_err", 128'(HDR_ERR), 128'd0);

    // back-pressure: toggling, then random
    rmode = 1;
    mk_file(32'hA1B2C3D4, 32'h0000FFFF, 32'd1, 40, 8'h00); model();
    send_file(1000); drain(); check_status();
    rmode = 2;
    mk_file(32'hD4C3B2A1, 32'h00010000, 32'h71000000, 117, 8'h55); model();
    send_file(1000); drain(); check_status();
    rmode = 0;

    // reset mid-STREAM, then a fresh file
    mk_file(32'hA1B2C3D4, 32'd64, 32'd1, 64, 8'h33); model();
    send_file(3);
    RST_N = 1'b0;
    expq.delete();
    #1;
    chk("t6_tvalid", 128'(PCAP_TVALID), 128'd0);
    chk("t6_hdr_ok", 128'(HDR_OK), 128'd0);
    chk("t6_snaplen", 128'(SNAPLEN), 128'd0);
    chk("t6_tready", 128'(S_TREADY), 128'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    mk_file(32'h4D3CB2A1, 32'hFFFF0000, 32'h01000000, 20, 8'h40); model();
    send_file(1000); drain(); check_status();
    chk("t6_snaplen_lit", 128'(SNAPLEN), 128'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
